cog_vid_sched: RTL and testbench

//   Sequences the cog video shifter. Queues the WAITVID (pixel,color) long pairs
//   the cog issues and keeps the shifter's pixel/color inputs loaded with the queue head.

---
 rtl/cog_vid_sched.sv | 151 +++++++++++++++
 tb/tb_cog_vid_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cog_vid_sched.sv
// Cog video scheduler: queues WAITVID (pixel,color) pairs and keeps the shifter inputs
// loaded with the queue head, popping on each rising edge of the shifter capture level.
module cog_vid_sched #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk_cog,
    input  logic          nres,
    input  logic          ena,
    input  logic          vid_en,
    input  logic          push,
    input  logic [31:0]   push_pixel,
    input  logic [31:0]   push_color,
    input  logic          ack,
    input  logic          clr_urun,
    output logic          stall,
    output logic [31:0]   pixel,
    output logic [31:0]   color,
    output logic [AW:0]   count,
    output logic          underrun,
    output logic [15:0]   urun_cnt
);

    typedef enum logic [1:0] {StOff, StPrime, StRun} state_e;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_e          state_q, state_d;
    logic            ack_q;
    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   rd_nxt;
    logic [31:0]     pixel_q, pixel_d;
    logic [31:0]     color_q, color_d;
    logic            underrun_q, underrun_d;
    logic [15:0]     urun_cnt_q, urun_cnt_d;
    logic [31:0]     pix_mem [DEPTH];
    logic [31:0]     col_mem [DEPTH];

    logic            flush;
    logic            cap_ev;
    logic            pop_now;
    logic            accept;
    logic            urun_ev;

    assign flush  = ~ena | ~vid_en;
    assign cap_ev = ack & ~ack_q;
    assign rd_nxt = rd_ptr_q + AW'(1);

    // State register
    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            state_q <= StOff;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StOff:   if (!flush) state_d = StPrime;
            StPrime: begin
                if (flush)       state_d = StOff;
                else if (accept) state_d = StRun;
            end
            StRun:   if (flush) state_d = StOff;
            default: state_d = StOff;
        endcase
    end

    // Control outputs; capture edges are ignored until the first entry is queued
    always_comb begin
        pop_now = (state_q == StRun) & cap_ev & (count_q != '0);
        urun_ev = (state_q == StRun) & cap_ev & (count_q == '0);
        accept  = push & (state_q != StOff) & ((count_q != FULL) | pop_now);
        stall   = push & (state_q != StOff) & (count_q == FULL) & ~pop_now;
    end

    // Queue bookkeeping and head register load
    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pixel_d    = pixel_q;
        color_d    = color_q;
        underrun_d = urun_ev;
        urun_cnt_d = urun_cnt_q;

        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (accept)  wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_now) rd_ptr_d = rd_nxt;
            if (accept && !pop_now)      count_d = count_q + (AW+1)'(1);
            else if (!accept && pop_now) count_d = count_q - (AW+1)'(1);

            // The pushed entry becomes head when the queue is (or is about to be) empty
            if (accept && ((count_q == '0) || (pop_now && count_q == (AW+1)'(1)))) begin
                pixel_d = push_pixel;
                color_d = push_color;
            end else if (pop_now && count_q > (AW+1)'(1)) begin
                pixel_d = pix_mem[rd_nxt];
                color_d = col_mem[rd_nxt];
            end
        end

        if (clr_urun)                           urun_cnt_d = '0;
        else if (urun_ev && urun_cnt_q != '1)   urun_cnt_d = urun_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            ack_q      <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pixel_q    <= '0;
            color_q    <= '0;
            underrun_q <= 1'b0;
            urun_cnt_q <= '0;
        end else begin
            ack_q      <= ack;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pixel_q    <= pixel_d;
            color_q    <= color_d;
            underrun_q <= underrun_d;
            urun_cnt_q <= urun_cnt_d;
        end
    end

    always_ff @(posedge clk_cog) begin
        if (accept && !flush) begin
            pix_mem[wr_ptr_q] <= push_pixel;
            col_mem[wr_ptr_q] <= push_color;
        end
    end

    assign pixel    = pixel_q;
    assign color    = color_q;
    assign count    = count_q;
    assign underrun = underrun_q;
    assign urun_cnt = urun_cnt_q;

endmodule

// File: tb/tb_cog_vid_sched.sv
// Directed bench for cog_vid_sched: queue fill/stall, capture-edge pops, underruns,
// flush, async reset and counter saturation.
module tb_cog_vid_sched;

    logic        clk_cog;
    logic        nres;
    logic        ena;
    logic        vid_en;
    logic        push;
    logic [31:0] push_pixel;
    logic [31:0] push_color;
    logic        ack;
    logic        clr_urun;
    logic        stall;
    logic [31:0] pixel;
    logic [31:0] color;
    logic [2:0]  count;
    logic        underrun;
    logic [15:0] urun_cnt;

    int n_total = 0;
    int n_pass  = 0;

    cog_vid_sched #(.DEPTH(4), .AW(2)) dut (
        .clk_cog    (clk_cog),
        .nres       (nres),
        .ena        (ena),
        .vid_en     (vid_en),
        .push       (push),
        .push_pixel (push_pixel),
        .push_color (push_color),
        .ack        (ack),
        .clr_urun   (clr_urun),
        .stall      (stall),
        .pixel      (pixel),
        .color      (color),
        .count      (count),
        .underrun   (underrun),
        .urun_cnt   (urun_cnt)
    );

    initial clk_cog = 1'b0;
    always #5 clk_cog = ~clk_cog;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_cog);
        #1;
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        nres = 1'b1; ena = 1'b0; vid_en = 1'b0; push = 1'b0; ack = 1'b0; clr_urun = 1'b0;
        push_pixel = '0; push_color = '0;
        #2 nres = 1'b0;
        tick();
        tick();
        n_total++;
        if ({pixel, color} !== 64'h0) $display("FAIL reset_data: pixel=%h color=%h want 0", pixel, color);
        else n_pass++;
        n_total++;
        if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count);
        else n_pass++;
        n_total++;
        if ({stall, underrun, urun_cnt} !== 18'h0)
            $display("FAIL reset_flags: stall=%b underrun=%b urun_cnt=%h want 0", stall, underrun, urun_cnt);
        else n_pass++;
        @(negedge clk_cog);
        nres = 1'b1;
    endtask

    task automatic test_first_push();
        ena = 1'b1; vid_en = 1'b1;
        tick();                            // OFF -> PRIME
        push = 1'b1; push_pixel = 32'h1111_1111; push_color = 32'h2222_2222;
        #1;
        n_total++;
        if (stall !== 1'b0) $display("FAIL first_stall: got %b want 0", stall);
        else n_pass++;
        tick();
        push = 1'b0;
        n_total++;
        if (pixel !== 32'h1111_1111 || color !== 32'h2222_2222)
            $display("FAIL first_data: pixel=%h color=%h want 11111111/22222222", pixel, color);
        else n_pass++;
        n_total++;
        if (count !== 3'd1) $display("FAIL first_count: got %0d want 1", count);
        else n_pass++;
    endtask

    task automatic test_full_stall();
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; push_pixel = 32'hB0 + i; push_color = 32'hC0 + i;
            tick();
        end
        n_total++;
        if (count !== 3'd4 || pixel !== 32'h1111_1111)
            $display("FAIL fill_count: count=%0d pixel=%h want 4/11111111", count, pixel);
        else n_pass++;
        push_pixel = 32'hE0; push_color = 32'hE1;
        #1;
        n_total++;
        if (stall !== 1'b1) $display("FAIL full_stall: got %b want 1", stall);
        else n_pass++;
        tick();
        n_total++;
        if (stall !== 1'b1 || count !== 3'd4)
            $display("FAIL stall_hold: stall=%b count=%0d want 1/4", stall, count);
        else n_pass++;
        ack = 1'b1;
        #1;
        n_total++;
        if (stall !== 1'b0) $display("FAIL stall_release: got %b want 0", stall);
        else n_pass++;
        tick();
        push = 1'b0;
        n_total++;
        if (count !== 3'd4 || pixel !== 32'hB0 || color !== 32'hC0)
            $display("FAIL push_pop_full: count=%0d pixel=%h color=%h want 4/b0/c0", count, pixel, color);
        else n_pass++;
        ack = 1'b0;
        tick();
    endtask

    task automatic test_ack_level();
        ack_pulse();                       // queue now B1,B2,E0
        n_total++;
        if (count !== 3'd3 || pixel !== 32'hB1)
            $display("FAIL pop_one: count=%0d pixel=%h want 3/b1", count, pixel);
        else n_pass++;
        ack = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        ack = 1'b0;
        n_total++;
        if (count !== 3'd2 || pixel !== 32'hB2 || color !== 32'hC2)
            $display("FAIL ack_level: count=%0d pixel=%h color=%h want 2/b2/c2", count, pixel, color);
        else n_pass++;
        tick();
    endtask

    task automatic test_underrun();
        ack_pulse();
        ack_pulse();
        n_total++;
        if (count !== 3'd0 || pixel !== 32'hE0 || underrun !== 1'b0)
            $display("FAIL drain: count=%0d pixel=%h underrun=%b want 0/e0/0", count, pixel, underrun);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            ack = 1'b1;
            tick();
            n_total++;
            if (underrun !== 1'b1) $display("FAIL urun_pulse%0d: got %b want 1", i, underrun);
            else n_pass++;
            ack = 1'b0;
            tick();
            n_total++;
            if (underrun !== 1'b0) $display("FAIL urun_low%0d: got %b want 0", i, underrun);
            else n_pass++;
        end
        n_total++;
        if (urun_cnt !== 16'd3 || pixel !== 32'hE0 || color !== 32'hE1)
            $display("FAIL urun_cnt: cnt=%0d pixel=%h color=%h want 3/e0/e1", urun_cnt, pixel, color);
        else n_pass++;
        clr_urun = 1'b1;
        tick();
        clr_urun = 1'b0;
        n_total++;
        if (urun_cnt !== 16'd0) $display("FAIL urun_clr: got %0d want 0", urun_cnt);
        else n_pass++;
        ack_pulse();
        clr_urun = 1'b1; ack = 1'b1;
        tick();
        clr_urun = 1'b0; ack = 1'b0;
        n_total++;
        if (urun_cnt !== 16'd0 || underrun !== 1'b1)
            $display("FAIL clr_wins: cnt=%0d underrun=%b want 0/1", urun_cnt, underrun);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        push = 1'b1; push_pixel = 32'hF0; push_color = 32'hF1;
        tick();
        push_pixel = 32'hA0; push_color = 32'hA1; ack = 1'b1;
        tick();
        push = 1'b0; ack = 1'b0;
        n_total++;
        if (count !== 3'd1 || pixel !== 32'hA0 || color !== 32'hA1 || underrun !== 1'b0)
            $display("FAIL b2b: count=%0d pixel=%h color=%h urun=%b want 1/a0/a1/0",
                     count, pixel, color, underrun);
        else n_pass++;
        push = 1'b1; push_pixel = 32'h90; push_color = 32'h91;
        tick();
        push = 1'b0;
        n_total++;
        if (count !== 3'd2 || pixel !== 32'hA0)
            $display("FAIL b2b_second: count=%0d pixel=%h want 2/a0", count, pixel);
        else n_pass++;
    endtask

    task automatic test_flush();
        vid_en = 1'b0;
        tick();
        n_total++;
        if (count !== 3'd0 || pixel !== 32'hA0)
            $display("FAIL flush: count=%0d pixel=%h want 0/a0", count, pixel);
        else n_pass++;
        push = 1'b1; push_pixel = 32'h55; push_color = 32'h66;
        #1;
        n_total++;
        if (stall !== 1'b0) $display("FAIL off_stall: got %b want 0", stall);
        else n_pass++;
        tick();
        push = 1'b0;
        vid_en = 1'b1;
        n_total++;
        if (count !== 3'd0 || pixel !== 32'hA0)
            $display("FAIL off_drop: count=%0d pixel=%h want 0/a0", count, pixel);
        else n_pass++;
        tick();                            // OFF -> PRIME
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_total++;
        if (underrun !== 1'b0 || urun_cnt !== 16'd0)
            $display("FAIL prime_ack: underrun=%b cnt=%0d want 0/0", underrun, urun_cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; push_pixel = 32'h70 + i; push_color = 32'h80 + i;
            tick();
        end
        push = 1'b0;
        n_total++;
        if (count !== 3'd3 || pixel !== 32'h70)
            $display("FAIL pre_reset: count=%0d pixel=%h want 3/70", count, pixel);
        else n_pass++;
        @(negedge clk_cog);
        #2 nres = 1'b0;
        #1;
        n_total++;
        if ({pixel, color} !== 64'h0 || count !== 3'd0 || stall !== 1'b0 ||
            underrun !== 1'b0 || urun_cnt !== 16'd0)
            $display("FAIL async_reset: pixel=%h color=%h count=%0d stall=%b urun=%b cnt=%h want 0",
                     pixel, color, count, stall, underrun, urun_cnt);
        else n_pass++;
        @(negedge clk_cog);
        nres = 1'b1;
    endtask

    task automatic test_saturate();
        tick();                            // OFF -> PRIME
        push = 1'b1; push_pixel = 32'h33; push_color = 32'h44;
        tick();
        push = 1'b0;
        ack_pulse();                       // RUN, empty
        force dut.urun_cnt_q = 16'hFFFE;
        tick();
        @(negedge clk_cog);
        release dut.urun_cnt_q;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_total++;
        if (urun_cnt !== 16'hFFFF || underrun !== 1'b1)
            $display("FAIL sat_reach: cnt=%h underrun=%b want ffff/1", urun_cnt, underrun);
        else n_pass++;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_total++;
        if (urun_cnt !== 16'hFFFF || underrun !== 1'b1)
            $display("FAIL sat_hold: cnt=%h underrun=%b want ffff/1", urun_cnt, underrun);
        else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_full_stall();
        test_ack_level();
        test_underrun();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
